// File: rtl/spi_sram_master.sv
// spi_sram_master
//   Single-byte read/write master for an SPI serial SRAM (mode 0, MSB first).
//   A request is accepted in IDLE with a valid/ready handshake. The block then
//   sends one 40-bit frame with cs_n held low: opcode, 24-bit address, then one
//   data byte. Each bit takes two clk cycles, with sclk low and then high.
//   The frame ends with a one-cycle rsp_valid pulse. cs_n then stays high for a
//   two-cycle gap before the next request can be accepted.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_wr                1 = write, 0 = read
//   req_addr[23:0]        byte address, sent verbatim
//   req_wdata[7:0]        write data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata[7:0]        read byte (8'h00 after a write), held until next rsp
//   cs_n, sclk, mosi      SPI outputs, all driven straight from flops
//   miso                  SPI input, sampled at the end of each sclk-low phase
module spi_sram_master #(
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP} state_e;

    localparam logic [5:0] LAST_BIT     = 6'd39;
    localparam logic [5:0] LAST_CMD_BIT = 6'd7;
    localparam logic [5:0] LAST_ADR_BIT = 6'd31;

    state_e      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;      // frame bit index; gap cycle count in GAP
    logic [39:0] shift_q, shift_d;          // bits still to send, next one at [39]
    logic [7:0]  rx_q, rx_d;
    logic        wr_q, wr_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic        in_frame;
    logic        frame_end;
    logic [39:0] frame_word;

    assign accept    = req_valid && ready_q;
    assign in_frame  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
    // The frame ends after the high phase of the last bit.
    assign frame_end = in_frame && sclk_q && (bit_cnt_q == LAST_BIT);
    assign frame_word = {req_wr ? CMD_WRITE : CMD_READ, req_addr,
                         req_wr ? req_wdata : 8'h00};

    // State register: every flop, including the registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment, so every flop
        // samples the values from before this edge.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_q        <= '0;
            wr_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state logic: sequencing, bit counter, shift registers.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        wr_d      = wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                    wr_d      = req_wr;
                    // Bit 0 goes straight to mosi; the rest wait in the shifter.
                    shift_d   = {frame_word[38:0], 1'b0};
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (!sclk_q) begin
                    // The rising sclk edge is the read-data sample point.
                    if (state_q == S_DATA && !wr_q) begin
                        rx_d = {rx_q[6:0], miso};
                    end
                end else if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_GAP;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    shift_d   = {shift_q[38:0], 1'b0};
                    if (bit_cnt_q == LAST_CMD_BIT) state_d = S_ADDR;
                    if (bit_cnt_q == LAST_ADR_BIT) state_d = S_DATA;
                end
            end
            S_GAP: begin
                if (bit_cnt_q == 6'd1) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        cs_n_d      = 1'b1;
        sclk_d      = 1'b0;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        ready_d     = (state_d == S_IDLE);
        if (state_q == S_IDLE && accept) begin
            cs_n_d = 1'b0;
            mosi_d = frame_word[39];
        end else if (in_frame) begin
            if (!sclk_q) begin
                cs_n_d = 1'b0;
                sclk_d = 1'b1;
                mosi_d = mosi_q;          // mosi stays stable while sclk is high
            end else if (frame_end) begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = wr_q ? 8'h00 : rx_q;
            end else begin
                cs_n_d = 1'b0;
                mosi_d = shift_q[39];
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cs_n      = cs_n_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_sram_master.sv
// Testbench for spi_sram_master. A behavioural SPI SRAM model records every
// complete 40-bit frame seen on mosi, commits writes, and serves read data on
// miso. Expected frames and responses are queued when each request is issued.
// They are popped and compared when the frame completes or rsp_valid fires.
module tb_spi_sram_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0]  exp_rsp_q[$];
    logic [39:0] exp_frame_q[$];
    logic [39:0] seen_frame_q[$];
    logic [7:0]  mem[logic [23:0]];

    spi_sram_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI SRAM model, evaluated on the falling clk edge, away from the DUT edge.
    logic [39:0] m_frame = '0;
    int          m_cnt = 0;
    logic        m_sclk_prev = 1'b0;
    logic        m_cs_prev = 1'b1;
    logic [7:0]  m_op = '0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_byte;

    always @(negedge clk) begin
        if (cs_n !== 1'b0) begin
            if (m_cs_prev === 1'b0 && m_cnt == 40) begin
                seen_frame_q.push_back(m_frame);
                if (m_frame[39:32] == 8'h02) mem[m_frame[31:8]] = m_frame[7:0];
            end
            m_cnt   = 0;
            m_frame = '0;
            miso    = 1'b0;
        end else if (sclk === 1'b1 && m_sclk_prev === 1'b0) begin
            m_frame = {m_frame[38:0], mosi};
            m_cnt++;
            if (m_cnt == 32) begin
                m_op   = m_frame[31:24];
                m_addr = m_frame[23:0];
            end
        end else if (sclk === 1'b0 && m_cnt >= 32 && m_cnt < 40 && m_op == 8'h03) begin
            m_byte = mem.exists(m_addr) ? mem[m_addr] : 8'h00;
            miso   = m_byte[39 - m_cnt];
        end
        m_sclk_prev = sclk;
        m_cs_prev   = cs_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and waits (bounded) for acceptance; returns in cycle T0+1.
    task automatic start_req(input logic wr, input logic [23:0] addr, input logic [7:0] wd,
                             input logic [7:0] exp_rd, input bit queue_exp, input string name);
        int n = 0;
        if (queue_exp) begin
            exp_rsp_q.push_back(exp_rd);
            exp_frame_q.push_back({wr ? 8'h02 : 8'h03, addr, wr ? wd : 8'h00});
        end
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept_wait: req_ready=%b after %0d cycles, required 1", name, req_ready, n);
        end
        tick();
    endtask

    // Observes cycles T0+1 .. T0+83 of one frame and checks timing and payload.
    task automatic watch_frame(input string name, output int rsp_abs);
        int cs_low = 0, cs_first = -1, n_rsp = 0, t_rsp = -1;
        int sclk_err = 0, idle_err = 0, ready_err = 0;
        logic [7:0]  exp_b;
        logic [7:0]  last_b = 8'h00;
        logic [39:0] f_exp, f_got;
        rsp_abs = -1;
        for (int c = 1; c <= 83; c++) begin
            if (cs_n === 1'b0) begin
                cs_low++;
                if (cs_first < 0) cs_first = c;
            end
            if (c <= 80) begin
                if (sclk !== ((c % 2) == 0)) sclk_err++;
            end else if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
                idle_err++;
            end
            if (c < 83 && req_ready !== 1'b0) ready_err++;
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                t_rsp = c;
                rsp_abs = cyc;
                total++;
                if (exp_rsp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s rsp_unqueued: rdata=%h, no response expected", name, rsp_rdata);
                end else begin
                    exp_b  = exp_rsp_q.pop_front();
                    last_b = exp_b;
                    if (rsp_rdata !== exp_b) begin
                        bad++;
                        $display("FAIL %s rsp_rdata: got %h, required %h", name, rsp_rdata, exp_b);
                    end
                end
            end
            if (c < 83) tick();
        end
        total++;
        if (cs_first !== 1) begin
            bad++;
            $display("FAIL %s cs_first: cs_n first low at T0+%0d, required T0+1", name, cs_first);
        end
        total++;
        if (cs_low !== 80) begin
            bad++;
            $display("FAIL %s cs_low: cs_n low %0d cycles, required 80", name, cs_low);
        end
        total++;
        if (n_rsp !== 1 || t_rsp !== 81) begin
            bad++;
            $display("FAIL %s rsp_timing: %0d pulses, last at T0+%0d, required 1 at T0+81", name, n_rsp, t_rsp);
        end
        total++;
        if (sclk_err !== 0) begin
            bad++;
            $display("FAIL %s sclk_phase: %0d wrong sclk cycles, required 0", name, sclk_err);
        end
        total++;
        if (idle_err !== 0) begin
            bad++;
            $display("FAIL %s gap_levels: %0d cycles with cs_n/sclk/mosi not 1/0/0, required 0", name, idle_err);
        end
        total++;
        if (ready_err !== 0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s req_ready: %0d busy cycles ready, ready at T0+83=%b, required 0 and 1", name, ready_err, req_ready);
        end
        total++;
        if (rsp_rdata !== last_b) begin
            bad++;
            $display("FAIL %s rdata_hold: got %h at T0+83, required %h", name, rsp_rdata, last_b);
        end
        total++;
        if (seen_frame_q.size() == 0 || exp_frame_q.size() == 0) begin
            bad++;
            $display("FAIL %s frame: seen %0d frames, expected %0d queued", name, seen_frame_q.size(), exp_frame_q.size());
        end else begin
            f_got = seen_frame_q.pop_front();
            f_exp = exp_frame_q.pop_front();
            if (f_got !== f_exp) begin
                bad++;
                $display("FAIL %s frame: mosi %h, required %h", name, f_got, f_exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        repeat (3) tick();
        total++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
            bad++;
            $display("FAIL reset_spi: cs_n/sclk/mosi=%b%b%b, required 100", cs_n, sclk, mosi);
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_rsp: rsp_valid=%b rdata=%h, required 0 00", rsp_valid, rsp_rdata);
        end
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: req_ready=%b during reset, required 0", req_ready);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: req_ready=%b first cycle out of reset, required 1", req_ready);
        end
    endtask

    task automatic test_read();
        int t;
        start_req(1'b0, 24'h000400, 8'h00, 8'hA9, 1'b1, "read");
        req_valid = 1'b0;
        watch_frame("read", t);
    endtask

    task automatic test_write();
        int t;
        start_req(1'b1, 24'h000200, 8'h2A, 8'h00, 1'b1, "write");
        req_valid = 1'b0;
        watch_frame("write", t);
        total++;
        if (!mem.exists(24'h000200) || mem[24'h000200] !== 8'h2A) begin
            bad++;
            $display("FAIL write mem: model byte at 000200 not 2A (present=%0d)", mem.exists(24'h000200));
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        start_req(1'b0, 24'h000010, 8'h00, 8'h5C, 1'b1, "b2b_first");
        // req_valid stays high; the second request is already on the inputs.
        req_addr = 24'h000011;
        exp_rsp_q.push_back(8'hC3);
        exp_frame_q.push_back({8'h03, 24'h000011, 8'h00});
        watch_frame("b2b_first", t1);
        tick();                                  // accepted at T0+83
        req_valid = 1'b0;
        watch_frame("b2b_second", t2);
        // Acceptance at T0+83 places the second pulse 83 cycles after the first
        // (82 cycles strictly between the pulses).
        total++;
        if (t2 - t1 !== 83) begin
            bad++;
            $display("FAIL b2b spacing: pulses %0d cycles apart, required 83", t2 - t1);
        end
    endtask

    task automatic test_ignore_midframe();
        int t;
        int cs_err = 0;
        start_req(1'b1, 24'h123456, 8'h77, 8'h00, 1'b1, "ignore");
        req_valid = 1'b0;
        fork
            watch_frame("ignore", t);
            begin
                repeat (10) tick();
                req_addr  = 24'hABCDEF;
                req_wdata = 8'h11;
                req_valid = 1'b1;
                repeat (3) tick();
                req_valid = 1'b0;
            end
        join
        for (int i = 0; i < 6; i++) begin
            if (cs_n !== 1'b1 || rsp_valid !== 1'b0) cs_err++;
            tick();
        end
        total++;
        if (cs_err !== 0 || mem.exists(24'hABCDEF) || seen_frame_q.size() != 0) begin
            bad++;
            $display("FAIL ignore extra_req: %0d active cycles, stray write=%0d, extra frames=%0d, required 0 0 0",
                     cs_err, mem.exists(24'hABCDEF), seen_frame_q.size());
        end
        total++;
        if (!mem.exists(24'h123456) || mem[24'h123456] !== 8'h77) begin
            bad++;
            $display("FAIL ignore mem: model byte at 123456 not 77 (present=%0d)", mem.exists(24'h123456));
        end
    endtask

    task automatic test_reset_midframe();
        int t;
        int stray = 0;
        start_req(1'b0, 24'h000400, 8'h00, 8'h00, 1'b0, "abort");
        req_valid = 1'b0;
        repeat (40) tick();                      // cycle T0+41, address phase
        rst_n = 1'b0;
        tick();
        total++;
        if (cs_n !== 1'b1) begin
            bad++;
            $display("FAIL abort cs_n: got %b the cycle after reset, required 1", cs_n);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0 || cs_n !== 1'b1) stray++;
            tick();
        end
        total++;
        if (stray !== 0 || rsp_rdata !== 8'h00 || seen_frame_q.size() != 0) begin
            bad++;
            $display("FAIL abort rsp: %0d stray cycles, rdata=%h, frames=%0d, required 0 00 0",
                     stray, rsp_rdata, seen_frame_q.size());
        end
        start_req(1'b0, 24'hFFFFFF, 8'h00, 8'h3E, 1'b1, "top_addr");
        req_valid = 1'b0;
        watch_frame("top_addr", t);
    endtask

    initial begin
        mem[24'h000400] = 8'hA9;
        mem[24'h000010] = 8'h5C;
        mem[24'h000011] = 8'hC3;
        mem[24'hFFFFFF] = 8'h3E;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        total++;
        if (exp_rsp_q.size() != 0 || exp_frame_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses and %0d frames still queued, required 0",
                     exp_rsp_q.size(), exp_frame_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
